fifo_read_demux: RTL and testbench
==================================

// Module: fifo_read_demux
// PURPOSE
//  Read-side counterpart of the generator-to-FIFO write path. Pops samples from the gen FIFO and
//  steers each one to one of four signed channel outputs, chosen by sel_i. Each channel has a
//  valid/ready handshake toward its consumer. Under !enh the outputs are gated to zero, matching
//  the write-side mux convention. Sits between the FIFO read port and the downstream consumers.
// PARAMETERS
//  DATA_WIDTH  `DATA_WIDTH (gen_fifo_defines_pkg)  sample width, signed
//  CNT_W       16                                  width of delivered-sample counter
// PORTS
//  clk          in   1           clock, all logic on posedge
//  rst          in   1           synchronous reset, active-high
//  enh          in   1           block enable; low gates all outputs to 0
//  sel_i        in   2           destination channel for the next pop (0..3)
//  fifo_empty_i in   1           FIFO empty flag
//  fifo_rd_en_o out  1           FIFO pop strobe (combinational)
//  fifo_data_i  in   DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en_o
//  data_0_o..data_3_o out DATA_WIDTH  signed channel data
//  valid_o      out  4           per-channel valid, one-hot or zero
//  ready_i      in   4           per-channel ready from consumer
//  count_o      out  CNT_W       samples delivered (handshakes completed), wraps
// BEHAVIOUR
//  - Reset: state=IDLE; fifo_rd_en_o=0, valid_o=0, data_N_o=0, count_o=0; hold reg/channel cleared.
//    Reset during WAIT/HOLD discards the popped sample; this loss is accepted.
//  - FSM IDLE -> WAIT -> HOLD:
//    IDLE: fifo_rd_en_o = enh & !fifo_empty_i & !rst. On pop, latch ch<=sel_i and go to WAIT.
//    WAIT: unconditionally capture hold<=fifo_data_i and go to HOLD. enh low does not abort this.
//    HOLD: valid_o[ch]=enh and data_ch_o=enh ? hold : 0. The other channels stay 0.
//      The handshake completes on valid_o[ch] & ready_i[ch]. Then count_o++ (modulo 2^CNT_W).
//      Back-to-back: if enh & !fifo_empty_i in the same cycle, pop again, latch new ch<=sel_i,
//      and go to WAIT. Otherwise go to IDLE.
//  - Timing: latency is pop at cycle t, valid_o at cycle t+2. Peak throughput is 1 sample per 2 cycles.
//  - fifo_rd_en_o is never high while fifo_empty_i=1 or rst=1, and is never high in WAIT.
//  - sel_i is sampled only at pop. Changes during WAIT/HOLD are ignored.
//  - enh low in HOLD: outputs and valid read 0, and no handshake completes. The sample is kept and
//    re-presented unchanged when enh returns.
//  - ready_i on non-selected channels is ignored.
//  - Data path carries the value bit-exact, signed, with no width conversion.
// TESTING (bench DATA_WIDTH=8)
//  1 Reset: rst=1 for 2 cycles, FIFO non-empty, enh=1 -> rd_en=0, valid_o=0, all data=0, count_o=0.
//  2 Single transfer: enh=1, sel_i=2, FIFO returns 8'h5A -> rd_en@t, valid_o=4'b0100 & data_2_o=8'h5A @t+2;
//    ready_i[2]=1 -> count_o=1 next cycle, valid_o=0.
//  3 Backpressure: in HOLD ready_i=0 for 5 cycles, sel_i->0 -> data_2_o stays 8'h5A, valid_o=4'b0100, no rd_en.
//  4 Enable gating: enh=0 in HOLD for 3 cycles -> all data=0, valid_o=0, count unchanged;
//    enh=1 -> 8'h5A back on data_2_o with valid_o[2]=1.
//  5 Stream: sel_i=3, FIFO {-80,-1,0,127}, ready_i=4'hF -> rd_en every 2nd cycle, values in order on
//    data_3_o, count_o=4. Then fifo_empty_i=1 -> rd_en stays 0.
//  6 Wrap with CNT_W=4: 16 completed transfers -> count_o returns to 0; reset in WAIT -> valid_o never rises.

Source files
------------

// File: rtl/fifo_read_demux.sv
// fifo_read_demux
// Pops samples from the generator FIFO and steers each one to one of four
// signed channel outputs, each with its own valid/ready handshake.
//
//  state | meaning
//  ------+----------------------------------------------------------------
//  IDLE  | nothing in flight; pop as soon as enabled and FIFO non-empty
//  WAIT  | pop issued last cycle; FIFO read data is captured this cycle
//  HOLD  | sample presented on the latched channel until the handshake
//
// A sample is presented two cycles after its pop. Back-to-back delivery
// pops again in the handshake cycle, giving one sample every two cycles.
// Dropping enh while holding blanks the outputs but keeps the sample, which
// is re-presented unchanged once enh returns.

module fifo_read_demux #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enh,
    input  logic [1:0]                   sel_i,
    input  logic                         fifo_empty_i,
    output logic                         fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0]        fifo_data_i,
    output logic signed [DATA_WIDTH-1:0] data_0_o,
    output logic signed [DATA_WIDTH-1:0] data_1_o,
    output logic signed [DATA_WIDTH-1:0] data_2_o,
    output logic signed [DATA_WIDTH-1:0] data_3_o,
    output logic [3:0]                   valid_o,
    input  logic [3:0]                   ready_i,
    output logic [CNT_W-1:0]             count_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [1:0]              ch_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic [CNT_W-1:0]        count_q;

    logic                    can_pop;
    logic                    presenting;
    logic                    handshake;
    logic                    pop;

    // A pop is only ever legal with the block enabled, data available and
    // reset released; the FSM decides whether it is also the right moment.
    assign can_pop    = enh & ~fifo_empty_i & ~rst;
    assign presenting = (state_q == ST_HOLD) & enh;
    assign handshake  = presenting & ready_i[ch_q];

    // Next-state and pop strobe decode.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Data arrives regardless of enh; the capture is never aborted.
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) begin
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Destination channel is sampled only at pop; later sel_i changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q <= 2'd0;
        end else if (pop) begin
            ch_q <= sel_i;
        end
    end

    // Capture the FIFO read data one cycle after the pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else if (state_q == ST_WAIT) begin
            hold_q <= fifo_data_i;
        end
    end

    // Delivered-sample counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (handshake) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    // Channel outputs: only the latched channel carries the sample, and only while enabled.
    always_comb begin
        valid_o  = 4'b0000;
        data_0_o = '0;
        data_1_o = '0;
        data_2_o = '0;
        data_3_o = '0;
        if (presenting) begin
            valid_o[ch_q] = 1'b1;
            case (ch_q)
                2'd0:    data_0_o = hold_q;
                2'd1:    data_1_o = hold_q;
                2'd2:    data_2_o = hold_q;
                default: data_3_o = hold_q;
            endcase
        end
    end

    assign fifo_rd_en_o = pop;
    assign count_o      = count_q;

endmodule

// File: tb/tb_fifo_read_demux.sv
// Bench for fifo_read_demux: directed scenarios followed by random traffic.
// A FIFO model feeds the DUT; a monitor predicts pop strobe, channel outputs
// and delivered count each cycle from a queue of popped-but-undelivered samples.

module tb_fifo_read_demux;

    localparam int DW    = 8;
    localparam int CW    = 4;
    localparam int CMOD  = 16;

    logic          clk;
    logic          rst;
    logic          enh;
    logic [1:0]    sel_i;
    logic          fifo_empty_i;
    logic          fifo_rd_en_o;
    logic [DW-1:0] fifo_data_i;
    logic signed [DW-1:0] data_0_o;
    logic signed [DW-1:0] data_1_o;
    logic signed [DW-1:0] data_2_o;
    logic signed [DW-1:0] data_3_o;
    logic [3:0]    valid_o;
    logic [3:0]    ready_i;
    logic [CW-1:0] count_o;

    fifo_read_demux #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .enh          (enh),
        .sel_i        (sel_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_data_i  (fifo_data_i),
        .data_0_o     (data_0_o),
        .data_1_o     (data_1_o),
        .data_2_o     (data_2_o),
        .data_3_o     (data_3_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO contents, owned by the stimulus process.
    logic [DW-1:0] fifo_q[$];
    logic          force_empty;
    logic          to_flag;

    // Scoreboard state, owned by the monitor process.
    typedef struct {
        int            ch;
        logic [DW-1:0] d;
        int            t;
    } exp_t;
    exp_t exp_q[$];
    int   cyc;
    int   model_cnt;
    int   pass_cnt;
    int   tot_cnt;
    logic to_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act !== exp) begin
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: predict and compare every cycle, away from the active edge.
    initial begin : mon
        logic          pres;
        logic          hs;
        logic          rd_exp;
        logic [3:0]    vexp;
        logic [31:0]   dexp;
        cyc       = 0;
        model_cnt = 0;
        pass_cnt  = 0;
        tot_cnt   = 0;
        to_seen   = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (to_flag && !to_seen) begin
                to_seen = 1'b1;
                tot_cnt++;
                $display("FAIL timeout cyc=%0d actual=fifo_not_drained required=drained", cyc);
            end
            if (rst) begin
                chk("rd_en_in_reset", 32'(fifo_rd_en_o), 32'd0);
                exp_q.delete();
                model_cnt = 0;
            end else begin
                pres   = (exp_q.size() != 0) && ((cyc - exp_q[0].t) >= 2);
                hs     = pres && enh && ready_i[exp_q[0].ch];
                rd_exp = enh && !fifo_empty_i && ((exp_q.size() == 0) || hs);
                vexp   = 4'b0000;
                dexp   = 32'd0;
                if (pres && enh) begin
                    vexp[exp_q[0].ch] = 1'b1;
                    dexp[exp_q[0].ch*8 +: 8] = exp_q[0].d;
                end
                chk("rd_en", 32'(fifo_rd_en_o), 32'(rd_exp));
                chk("valid", 32'(valid_o), 32'(vexp));
                chk("data", {data_3_o, data_2_o, data_1_o, data_0_o}, dexp);
                chk("count", 32'(count_o), 32'(model_cnt));
                if (hs) begin
                    void'(exp_q.pop_front());
                    model_cnt = (model_cnt + 1) % CMOD;
                end
                if (fifo_rd_en_o && fifo_q.size() > 0) begin
                    exp_q.push_back('{ch: int'(sel_i), d: fifo_q[0], t: cyc});
                end
            end
        end
    end

    task automatic upd_empty();
        fifo_empty_i = (fifo_q.size() == 0) || force_empty;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        upd_empty();
    endtask

    // One clock: observe the pop strobe, then deliver FIFO data just after the edge.
    task automatic tick();
        logic do_pop;
        @(negedge clk);
        do_pop = fifo_rd_en_o;
        @(posedge clk);
        #1;
        if (do_pop && fifo_q.size() > 0) begin
            fifo_data_i = fifo_q.pop_front();
        end
        upd_empty();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (fifo_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        if (fifo_q.size() != 0) to_flag = 1'b1;
    endtask

    initial begin : stim
        rst         = 1'b1;
        enh         = 1'b1;
        sel_i       = 2'd2;
        ready_i     = 4'b0000;
        fifo_data_i = '0;
        force_empty = 1'b0;
        to_flag     = 1'b0;
        fifo_q.delete();
        push(8'h5A);

        // Reset with FIFO non-empty and enabled.
        ticks(2);
        rst = 1'b0;

        // Single transfer to channel 2, then backpressure with sel_i moving.
        ticks(3);
        sel_i   = 2'd0;
        ready_i = 4'b1011;
        ticks(5);

        // Enable gating while holding.
        enh = 1'b0;
        ticks(3);
        enh = 1'b1;
        ticks(1);
        ready_i = 4'b0100;
        ticks(1);
        ready_i = 4'b0000;
        ticks(2);

        // Stream to channel 3 with all consumers ready.
        sel_i   = 2'd3;
        ready_i = 4'hF;
        push(8'hB0);
        push(8'hFF);
        push(8'h00);
        push(8'h7F);
        drain(30);
        ticks(6);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            enh         = ($urandom % 8) != 0;
            sel_i       = 2'($urandom);
            ready_i     = 4'($urandom);
            force_empty = ($urandom % 6) == 0;
            rst         = ($urandom % 300) == 0;
            if (($urandom % 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(8'($urandom));
            upd_empty();
            tick();
        end
        rst         = 1'b0;
        force_empty = 1'b0;
        enh         = 1'b1;
        ready_i     = 4'hF;
        drain(100);
        ticks(4);

        // Counter wrap: reset, then 16 completed transfers.
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(8'(i * 7 + 3));
        end
        drain(100);
        ticks(6);

        // Reset while the popped sample is in flight: it must never be presented.
        ready_i = 4'b0000;
        push(8'h33);
        drain(10);
        rst         = 1'b1;
        force_empty = 1'b1;
        upd_empty();
        ticks(1);
        rst = 1'b0;
        ticks(8);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
